// File: rtl/two_one_arb.sv
// two_one_arb: two-requester round-robin arbiter driving a shared WIDTH-bit mux.
// Grants, mux select and valid are registered; y is the gated mux output.
// Optional feature: define TWO_ONE_ARB_TIMEOUT_EN to bound each ownership to
// MAX_HOLD consecutive cycles whenever the other requester is waiting.
module two_one_arb #(
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             s0,
  output logic [WIDTH-1:0] y,
  output logic             valid
);

  // MAX_HOLD must fit the 8-bit hold counter and leave room for a handoff.
  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("two_one_arb: MAX_HOLD must be in 2..255");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   ptr_q, ptr_d;    // 0: requester 0 wins a tie, 1: requester 1 wins
  logic   s0_q, s0_d;
  logic   gnt0_q, gnt1_q;

`ifdef TWO_ONE_ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_MAX   = 8'(MAX_HOLD);
  // hold_q counts completed cycles, so MAX_HOLD-1 marks the last owned cycle.
  localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD - 1);
  logic [7:0] hold_q, hold_d;
  logic       expired;
  assign expired = (hold_q >= HOLD_LIMIT);
`endif

  // Next-state, pointer and select update; side effects happen on grant entry.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    s0_d    = s0_q;
    case (state_q)
      IDLE: begin
        if (req0 && req1)  state_d = ptr_q ? OWN1 : OWN0;
        else if (req0)     state_d = OWN0;
        else if (req1)     state_d = OWN1;
      end
      OWN0: begin
        if (!req0)         state_d = req1 ? OWN1 : IDLE;
`ifdef TWO_ONE_ARB_TIMEOUT_EN
        else if (req1 && expired) state_d = OWN1;
`endif
      end
      OWN1: begin
        if (!req1)         state_d = req0 ? OWN0 : IDLE;
`ifdef TWO_ONE_ARB_TIMEOUT_EN
        else if (req0 && expired) state_d = OWN0;
`endif
      end
      default:             state_d = IDLE;
    endcase
    // Whoever just got the mux gives tie priority to the other side.
    if (state_d == OWN0 && state_q != OWN0) begin
      ptr_d = 1'b1;
      s0_d  = 1'b0;
    end
    if (state_d == OWN1 && state_q != OWN1) begin
      ptr_d = 1'b0;
      s0_d  = 1'b1;
    end
  end

`ifdef TWO_ONE_ARB_TIMEOUT_EN
  // Hold counter: restarts on every ownership change or IDLE, saturates at MAX_HOLD.
  always_comb begin
    hold_d = hold_q;
    if (state_d == IDLE || state_d != state_q) hold_d = 8'd0;
    else if (hold_q != HOLD_MAX)               hold_d = hold_q + 8'd1;
  end
`endif

  // State, pointer, select and grant registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      s0_q    <= 1'b0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
`ifdef TWO_ONE_ARB_TIMEOUT_EN
      hold_q  <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      s0_q    <= s0_d;
      gnt0_q  <= (state_d == OWN0);
      gnt1_q  <= (state_d == OWN1);
`ifdef TWO_ONE_ARB_TIMEOUT_EN
      hold_q  <= hold_d;
`endif
    end
  end

  assign gnt0  = gnt0_q;
  assign gnt1  = gnt1_q;
  assign s0    = s0_q;
  assign valid = gnt0_q | gnt1_q;

  // Data path: selected input while someone owns the mux, zeros otherwise.
  always_comb begin
    y = '0;
    if (valid) y = s0_q ? i1 : i0;
  end

endmodule

// File: tb/tb_two_one_arb.sv
// Testbench for two_one_arb: directed vector table, a long-ownership sequence
// and randomized traffic compared against a behavioural arbitration model.
module tb_two_one_arb;

  localparam int W  = 8;
  localparam int MH = 4;

  logic         clk = 1'b0;
  logic         rst, req0, req1;
  logic [W-1:0] i0, i1, y;
  logic         gnt0, gnt1, s0, valid;

  int checks = 0;
  int errors = 0;

  two_one_arb #(.WIDTH(W), .MAX_HOLD(MH)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .i0(i0), .i1(i1),
    .gnt0(gnt0), .gnt1(gnt1), .s0(s0), .y(y), .valid(valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         rst, r0, r1;
    logic [W-1:0] d0, d1;
    logic         g0, g1, sel, v;
    logic [W-1:0] yy;
  } vec_t;

  vec_t vecs[$];

  // Behavioural model: who owns the mux, who wins the next tie, how long held.
  int   m_owner;   // -1 none, 0 or 1
  int   m_ptr;
  int   m_held;    // cycles the current owner has had the grant
  logic m_sel;

  task automatic model_step(input logic r, input logic q0, input logic q1);
    int nxt;
    logic mine, other;
    if (r) begin
      m_owner = -1; m_ptr = 0; m_held = 0; m_sel = 1'b0;
      return;
    end
    nxt = m_owner;
    if (m_owner < 0) begin
      if (q0 && q1) nxt = m_ptr;
      else if (q0)  nxt = 0;
      else if (q1)  nxt = 1;
    end else begin
      mine  = (m_owner == 0) ? q0 : q1;
      other = (m_owner == 0) ? q1 : q0;
      if (!mine) nxt = other ? 1 - m_owner : -1;
`ifdef TWO_ONE_ARB_TIMEOUT_EN
      else if (other && m_held >= MH) nxt = 1 - m_owner;
`endif
    end
    if (nxt < 0)              m_held = 0;
    else if (nxt != m_owner)  m_held = 1;
    else if (m_held < MH)     m_held = m_held + 1;
    if (nxt >= 0 && nxt != m_owner) begin
      m_ptr = 1 - nxt;
      m_sel = (nxt == 1);
    end
    m_owner = nxt;
  endtask

  task automatic check(input string name, input logic [W+3:0] got, input logic [W+3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got {gnt0,gnt1,s0,valid,y}=%b_%h required %b_%h",
               name, got[W+3:W], got[W-1:0], exp[W+3:W], exp[W-1:0]);
    end
  endtask

  task automatic cycle(input logic r, input logic q0, input logic q1,
                       input logic [W-1:0] d0, input logic [W-1:0] d1);
    rst = r; req0 = q0; req1 = q1; i0 = d0; i1 = d1;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(logic r, logic q0, logic q1, logic g0, logic g1,
                              logic sel, logic [W-1:0] yy);
    vec_t v;
    v.rst = r; v.r0 = q0; v.r1 = q1; v.d0 = 8'hA5; v.d1 = 8'h3C;
    v.g0 = g0; v.g1 = g1; v.sel = sel; v.v = g0 | g1; v.yy = yy;
    return v;
  endfunction

  initial begin
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; i0 = '0; i1 = '0;

    // Directed table: rst, req0, req1 -> gnt0, gnt1, s0, y (i0=A5, i1=3C).
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 8'h00)); // reset state
    vecs.push_back(mk(0, 1, 1, 1, 0, 0, 8'hA5)); // tie after reset -> req0
    vecs.push_back(mk(0, 1, 1, 1, 0, 0, 8'hA5)); // owner keeps grant
    vecs.push_back(mk(0, 0, 1, 0, 1, 1, 8'h3C)); // direct handoff, no IDLE
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 8'h00)); // IDLE, s0 holds
    vecs.push_back(mk(0, 0, 1, 0, 1, 1, 8'h3C)); // req1 only, 3 cycles
    vecs.push_back(mk(0, 0, 1, 0, 1, 1, 8'h3C));
    vecs.push_back(mk(0, 0, 1, 0, 1, 1, 8'h3C));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 8'h00)); // back to IDLE
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 8'h00)); // s0 still 1
    vecs.push_back(mk(0, 0, 1, 0, 1, 1, 8'h3C));
    vecs.push_back(mk(1, 1, 1, 0, 0, 0, 8'h00)); // reset mid-grant
    vecs.push_back(mk(0, 1, 1, 1, 0, 0, 8'hA5)); // pointer reset to req0
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 8'h00));
    vecs.push_back(mk(0, 1, 1, 0, 1, 1, 8'h3C)); // pointer now at req1
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 8'h00));
    vecs.push_back(mk(0, 1, 1, 1, 0, 0, 8'hA5)); // pointer back at req0
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 8'h00));
    vecs.push_back(mk(0, 1, 0, 1, 0, 0, 8'hA5)); // lone req0 moves pointer to 1
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 8'h00));
    vecs.push_back(mk(0, 1, 1, 0, 1, 1, 8'h3C)); // tie goes to req1
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 8'h00));

    foreach (vecs[k]) begin
      cycle(vecs[k].rst, vecs[k].r0, vecs[k].r1, vecs[k].d0, vecs[k].d1);
      check($sformatf("vec%0d", k), {gnt0, gnt1, s0, valid, y},
            {vecs[k].g0, vecs[k].g1, vecs[k].sel, vecs[k].v, vecs[k].yy});
    end

    // Both requests held continuously after reset.
    cycle(1, 0, 0, 8'h11, 8'h22);
    for (int k = 0; k < 16; k++) begin
      logic eg0;
      cycle(0, 1, 1, 8'h11, 8'h22);
`ifdef TWO_ONE_ARB_TIMEOUT_EN
      eg0 = ((k / MH) % 2) == 0;
`else
      eg0 = 1'b1;
`endif
      check($sformatf("hold%0d", k), {gnt0, gnt1, s0, valid, y},
            {eg0, ~eg0, ~eg0, 1'b1, eg0 ? 8'h11 : 8'h22});
    end

    // Randomized traffic against the behavioural model.
    cycle(1, 0, 0, 8'h00, 8'h00);
    model_step(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 600; k++) begin
      logic r, q0, q1;
      logic [W-1:0] d0, d1, ey;
      r  = ($urandom_range(0, 49) == 0);
      q0 = ($urandom_range(0, 9) < 6);
      q1 = ($urandom_range(0, 9) < 6);
      d0 = W'($urandom);
      d1 = W'($urandom);
      model_step(r, q0, q1);
      cycle(r, q0, q1, d0, d1);
      ey = (m_owner == 0) ? d0 : (m_owner == 1) ? d1 : '0;
      check($sformatf("rand%0d", k), {gnt0, gnt1, s0, valid, y},
            {m_owner == 0, m_owner == 1, m_sel, m_owner >= 0, ey});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
